// File: rtl/tc_timer.sv
// -----------------------------------------------------------------------------
// tc_timer
//
// Memory-mapped countdown timer. Software programs a PRESET value and enables
// the timer through CTRL. The timer loads PRESET into COUNT, counts down to
// zero and then raises an interrupt flag. In one-shot mode the flag is held
// and the timer disables itself. In auto-reload mode the flag lasts one cycle
// and the timer restarts on its own. Any write to CTRL or PRESET acknowledges
// (clears) the interrupt flag.
//
// Register map (word addressed, addr[3:2]):
//   0 CTRL   : bit0 EN, bits2:1 MODE (01 = auto-reload, else one-shot),
//              bit3 IM (interrupt mask/enable), bits31:4 read as 0
//   1 PRESET : 32-bit read/write reload value
//   2 COUNT  : read-only current count
//   3 -      : unmapped, reads 0
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   addr   : byte address from the bridge, only bits 3:2 decoded
//   we     : write strobe
//   wdata  : write data
//   rdata  : combinational read data for addr[3:2]
//   irq    : interrupt request = irq_flag & IM
// -----------------------------------------------------------------------------
module tc_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        unused_addr_bits;

  assign wr_ctrl          = we && (addr[3:2] == 2'd0);
  assign wr_preset        = we && (addr[3:2] == 2'd1);
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // FSM updates are computed first; bus writes are applied afterwards so a
  // software write to the same field in the same cycle always wins.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      IDLE: begin
        if (en_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // COUNT of 0 or 1 both expire here, so PRESET=0 acts like 1
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        // Only MODE 01 auto-reloads; 00, 10 and 11 are one-shot
        if (mode_q == 2'b01) begin
          irq_flag_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl) begin
      en_d       = wdata[0];
      mode_d     = wdata[2:1];
      im_d       = wdata[3];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = wdata;
      irq_flag_d = 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & im_q;

endmodule
